// File: rtl/ascii_to_binary.sv
// rtl/ascii_to_binary.sv - signed decimal ASCII field to two's-complement parser
//
// Accepts one ASCII character per cycle and parses an optional sign, 1..MAX_DIGITS
// decimal digits and a terminator (CR, LF, ',' or space). The result is a WIDTH-bit
// two's-complement value. Each terminated field produces exactly one pulse:
// value_valid for a good field, or error for a malformed one.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   enable       gates character acceptance; state and outputs hold while low
//   in_valid     in_char carries a character this cycle
//   in_char      ASCII character
//   in_ready     enable & reset; a character is consumed on in_valid & in_ready
//   value        last committed value, two's complement
//   is_negative  sign of value
//   value_valid  one-cycle pulse, value/is_negative just updated
//   error        one-cycle pulse, malformed field detected

module ascii_to_binary #(
   parameter int WIDTH      = 13,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             in_valid,
   input  logic [7:0]       in_char,
   output logic             in_ready,
   output logic [WIDTH-1:0] value,
   output logic             is_negative,
   output logic             value_valid,
   output logic             error
);

   // acc holds a magnitude up to 2^(WIDTH-1), which needs one bit beyond WIDTH-1.
   // The product acc*10+9 needs three more bits on top of that.
   localparam int AW  = WIDTH + 1;
   localparam int IW  = WIDTH + 4;
   localparam int NDW = $clog2(MAX_DIGITS + 1);

   localparam logic [AW-1:0]  ACC_LIMIT  = AW'(1) << (WIDTH - 1);
   localparam logic [IW-1:0]  PROD_LIMIT = IW'(1) << (WIDTH - 1);
   localparam logic [NDW-1:0] NDIG_MAX   = NDW'(MAX_DIGITS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SIGNED = 2'd1,
      S_DIGITS = 2'd2,
      S_SKIP   = 2'd3
   } state_t;

   state_t           r_state;
   logic [AW-1:0]    r_acc;
   logic [NDW-1:0]   r_ndig;
   logic             r_neg;
   logic [WIDTH-1:0] r_value;
   logic             r_is_negative;
   logic             r_value_valid;
   logic             r_error;

   state_t           w_state_nx;
   logic [AW-1:0]    w_acc_nx;
   logic [NDW-1:0]   w_ndig_nx;
   logic             w_neg_nx;
   logic             w_commit;
   logic             w_fail;

   logic             w_fire;
   logic             w_is_digit;
   logic             w_is_sign;
   logic             w_is_term;
   logic [3:0]       w_digit;
   logic [IW-1:0]    w_acc_ext;
   logic [IW-1:0]    w_prod;
   logic [AW-1:0]    w_acc_neg;
   logic [WIDTH-1:0] w_value_nx;
   logic             w_is_negative_nx;

   assign in_ready    = enable & reset;
   assign w_fire      = in_valid & in_ready;

   assign value       = r_value;
   assign is_negative = r_is_negative;
   assign value_valid = r_value_valid;
   assign error       = r_error;

   // Character classification
   assign w_is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
   assign w_is_sign  = (in_char == 8'h2D) || (in_char == 8'h2B);
   assign w_is_term  = (in_char == 8'h0D) || (in_char == 8'h0A) ||
                       (in_char == 8'h2C) || (in_char == 8'h20);
   // For '0'..'9' the low nibble is the digit value
   assign w_digit    = in_char[3:0];

   // acc*10 + d as shift-and-add
   assign w_acc_ext  = IW'(r_acc);
   assign w_prod     = (w_acc_ext << 3) + (w_acc_ext << 1) + IW'(w_digit);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_ndig  <= '0;
         r_neg   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_acc   <= w_acc_nx;
         r_ndig  <= w_ndig_nx;
         r_neg   <= w_neg_nx;
      end
   end

   // Next-state logic; nothing moves unless a character is consumed
   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_ndig_nx  = r_ndig;
      w_neg_nx   = r_neg;
      w_commit   = 1'b0;
      w_fail     = 1'b0;

      if (w_fire) begin
         case (r_state)
            S_IDLE: begin
               if (w_is_digit) begin
                  w_acc_nx   = AW'(w_digit);
                  w_ndig_nx  = NDW'(1);
                  w_neg_nx   = 1'b0;
                  w_state_nx = S_DIGITS;
               end else if (w_is_sign) begin
                  w_neg_nx   = (in_char == 8'h2D);
                  w_state_nx = S_SIGNED;
               end else if (!w_is_term) begin
                  w_fail     = 1'b1;
                  w_state_nx = S_SKIP;
               end
            end

            S_SIGNED: begin
               if (w_is_digit) begin
                  w_acc_nx   = AW'(w_digit);
                  w_ndig_nx  = NDW'(1);
                  w_state_nx = S_DIGITS;
               end else if (w_is_term) begin
                  // Bare sign: the field ends here, so no skipping is needed
                  w_fail     = 1'b1;
                  w_state_nx = S_IDLE;
               end else begin
                  w_fail     = 1'b1;
                  w_state_nx = S_SKIP;
               end
            end

            S_DIGITS: begin
               if (w_is_digit) begin
                  if (r_ndig == NDIG_MAX) begin
                     w_fail     = 1'b1;
                     w_state_nx = S_SKIP;
                  end else if (w_prod > PROD_LIMIT) begin
                     w_fail     = 1'b1;
                     w_state_nx = S_SKIP;
                  end else begin
                     w_acc_nx  = w_prod[AW-1:0];
                     w_ndig_nx = r_ndig + NDW'(1);
                  end
               end else if (w_is_term) begin
                  // 2^(WIDTH-1) is only representable as a negative value
                  if (!r_neg && (r_acc == ACC_LIMIT)) begin
                     w_fail = 1'b1;
                  end else begin
                     w_commit = 1'b1;
                  end
                  w_state_nx = S_IDLE;
               end else begin
                  w_fail     = 1'b1;
                  w_state_nx = S_SKIP;
               end
            end

            S_SKIP: begin
               if (w_is_term) begin
                  w_state_nx = S_IDLE;
               end
            end

            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   // Output logic: value to load on a commit
   always_comb begin
      w_acc_neg        = AW'(0) - r_acc;
      w_value_nx       = r_neg ? w_acc_neg[WIDTH-1:0] : r_acc[WIDTH-1:0];
      // "-0" commits as a plain zero
      w_is_negative_nx = r_neg & (r_acc != '0);
   end

   // Output registers; pulses clear every cycle, enabled or not
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_value       <= '0;
         r_is_negative <= 1'b0;
         r_value_valid <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_value_valid <= w_commit;
         r_error       <= w_fail;
         if (w_commit) begin
            r_value       <= w_value_nx;
            r_is_negative <= w_is_negative_nx;
         end
      end
   end

endmodule

// File: doc/ascii_to_binary.md
# ascii_to_binary

Parses a stream of ASCII characters carrying one signed decimal field (optional sign, 1..MAX_DIGITS digits, terminator) into a WIDTH-bit two's-complement value. It is the inverse of the accelerometer binary-to-ASCII path. It sits behind the UART receive byte interface and turns host-entered numbers (thresholds, offsets, test values) into register-ready binary. One character is accepted per cycle through a valid/ready handshake. A result or error pulse is produced per terminated field.

## Interface
- WIDTH, 13: output width; signed range -2^(WIDTH-1) .. 2^(WIDTH-1)-1 (-4096..4095 at default).
- MAX_DIGITS, 4: maximum decimal digits per field.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  gates acceptance; when low, state and outputs hold.
- in_valid  input  1  in_char is valid this cycle.
- in_char  input  8  ASCII character.
- in_ready  output  1  combinational: `enable & reset`; a character is consumed when `in_valid & in_ready`.
- value  output  WIDTH  last successfully parsed value, two's complement.
- is_negative  output  1  sign of `value`.
- value_valid  output  1  one-cycle pulse: value/is_negative just updated.
- error  output  1  one-cycle pulse: malformed field detected.

## Operation
- Character classes:
  - DIGIT '0'..'9' (0x30..0x39).
  - SIGN '-' (0x2D) or '+' (0x2B).
  - TERM CR 0x0D, LF 0x0A, ',' 0x2C, space 0x20.
  - Anything else is OTHER.
- State: `{IDLE, SIGNED, DIGITS, SKIP}`. Registers: acc (WIDTH+1 bits, magnitude), ndig (digit count), neg (pending sign).
- IDLE:
  - TERM: ignored; leading separators are allowed.
  - SIGN: neg = (char=='-'), go to SIGNED.
  - DIGIT: acc = d, ndig = 1, neg = 0, go to DIGITS.
  - OTHER: error, go to SKIP.
- SIGNED:
  - DIGIT: acc = d, ndig = 1, go to DIGITS.
  - TERM: error (sign with no digits), go to IDLE.
  - SIGN or OTHER: error, go to SKIP.
- DIGITS:
  - DIGIT, digit-count check: if ndig == MAX_DIGITS, error and go to SKIP.
  - DIGIT, accumulate: compute acc*10 + d as (acc<<3)+(acc<<1)+d, in an intermediate WIDTH+4 bits wide.
  - DIGIT, overflow check: if the result > 2^(WIDTH-1), error and go to SKIP. Otherwise store it and increment ndig.
  - TERM, positive overflow: if !neg and acc == 2^(WIDTH-1), error and go to IDLE.
  - TERM, commit: value = neg ? -acc : acc (low WIDTH bits), is_negative = neg & (acc != 0), pulse value_valid, go to IDLE.
  - SIGN or OTHER: error, go to SKIP.
- SKIP:
  - Discard everything until TERM, then go to IDLE. No further error pulses for that field.
- "-0" commits value 0 with is_negative 0. Leading zeros count toward MAX_DIGITS.
- On error, value and is_negative retain the last committed result.
- enable low: in_ready low, nothing consumed, FSM and outputs frozen. Pulses never stretch; value_valid and error are cleared on the next enabled or disabled cycle.

## Timing
- Reset (reset==0 at clk edge):
  - Outputs: value=0, is_negative=0, value_valid=0, error=0.
  - State: state=IDLE, acc=0, ndig=0, neg=0.
  - in_ready=0 while reset is low.
- Reset mid-field discards the partial field. The first post-reset character starts a fresh field.
- Throughput: one character per cycle, no stall states. in_ready never drops because of parsing.
- Latency: a terminator consumed on edge N has value, is_negative and value_valid visible after edge N. value_valid is high for exactly the cycle between edges N and N+1.
- Errors use the same latency: error is high for one cycle after the offending character is consumed.
- value_valid and error are never high in the same cycle.
- A new field may begin on the cycle immediately after its terminator. Back-to-back fields produce value_valid pulses one cycle apart at minimum.

## Test plan
- "-123\r" streamed, one char/cycle -> value=0x1F85, is_negative=1, one value_valid pulse the cycle after '\r', no error.
- "4095," then "-4096\n" -> value=0x0FFF (is_negative=0), then value=0x1000 (is_negative=1); two pulses, no error.
- "4096\r" after a commit of 7 -> error pulse after '\r'; value stays 0x0007; following "  12\r" commits 0x000C (leading spaces ignored).
- "12a4\r7\r" -> one error pulse after 'a'; '4' and '\r' skipped silently; then value=0x0007 with value_valid.
- "12345\r" (MAX_DIGITS=4) -> error after the 5th digit, remainder skipped; "-\r" -> error after '\r'; "--1\r" -> error after the second '-'.
- Mid-field and gating:
  - "-12", then reset low for 2 cycles, then "3\r" -> value=0x0003, is_negative=0; all outputs 0 during reset.
  - Repeat "-5\r" with enable low for 3 cycles between '-' and '5': in_ready low and nothing consumed while disabled; result 0x1FFB.
